// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator call scheduler.
// The state names match the controller's four operating modes.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_NUM_FLOORS  = 16;
    localparam int DEF_MOVE_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/elevator_next_call.sv
// Combinational search for the nearest pending floor in the travel direction,
// plus flags telling whether any calls lie above or below the car.
module elevator_next_call
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic                  any_above,
    output logic                  any_below,
    output logic [FLOOR_W-1:0]    target_floor
);

    logic [NUM_FLOORS-1:0] above;
    logic [NUM_FLOORS-1:0] below;

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_split
            assign above[gi] = pending[gi] && (FLOOR_W'(gi) > current_floor);
            assign below[gi] = pending[gi] && (FLOOR_W'(gi) < current_floor);
        end
    endgenerate

    assign any_above = |above;
    assign any_below = |below;

    // Scan order makes the last hit the one closest to the car.
    always_comb begin
        target_floor = current_floor;
        if (dir_up) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (above[i]) target_floor = FLOOR_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (below[i]) target_floor = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// LOOK-order elevator sequencer: latches floor calls, steps the car one floor
// per MOVE_CYCLES clocks and holds the door open DOOR_CYCLES clocks per stop.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived
);

    localparam int MOVE_CNT_W = $clog2(MOVE_CYCLES + 1);
    localparam int DOOR_CNT_W = $clog2(DOOR_CYCLES + 1);

    state_t                  state;
    logic [MOVE_CNT_W-1:0]   move_cnt;
    logic [DOOR_CNT_W-1:0]   door_cnt;

    logic                    any_above;
    logic                    any_below;
    logic                    move_done;
    logic                    door_done;
    logic                    in_move;
    logic                    enter_door_idle;
    logic                    enter_door_move;
    logic [FLOOR_W-1:0]      step_floor;
    logic [NUM_FLOORS-1:0]   clear;

    elevator_next_call #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_next_call (
        .pending       (pending),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .any_above     (any_above),
        .any_below     (any_below),
        .target_floor  (target_floor)
    );

    assign in_move         = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign move_done       = (move_cnt == MOVE_CNT_W'(MOVE_CYCLES - 1));
    assign door_done       = (door_cnt == DOOR_CNT_W'(DOOR_CYCLES - 1));
    assign step_floor      = (state == MOVE_UP) ? current_floor + 1'b1 : current_floor - 1'b1;
    assign enter_door_idle = (state == IDLE) && pending[current_floor];
    assign enter_door_move = in_move && move_done && pending[step_floor];

    // The bit being served is wiped on the opening edge and for as long as the
    // door stays open, so a same-floor call never survives into pending.
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_clear
            assign clear[gi] = ((state == DOOR_OPEN || enter_door_idle) && current_floor == FLOOR_W'(gi))
                             || (enter_door_move && step_floor == FLOOR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= '0;
            current_floor <= '0;
            dir_up        <= DIR_UP;
            moving        <= 1'b0;
            door_open     <= 1'b0;
            arrived       <= 1'b0;
            move_cnt      <= '0;
            door_cnt      <= '0;
        end else begin
            pending <= (pending | call_req) & ~clear;
            arrived <= 1'b0;
            case (state)
                IDLE: begin
                    if (enter_door_idle) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        arrived   <= 1'b1;
                        door_cnt  <= '0;
                    end else if (any_above && (dir_up || !any_below)) begin
                        state    <= MOVE_UP;
                        dir_up   <= DIR_UP;
                        moving   <= 1'b1;
                        move_cnt <= '0;
                    end else if (any_below) begin
                        state    <= MOVE_DOWN;
                        dir_up   <= DIR_DOWN;
                        moving   <= 1'b1;
                        move_cnt <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (move_done) begin
                        current_floor <= step_floor;
                        move_cnt      <= '0;
                        if (enter_door_move) begin
                            state     <= DOOR_OPEN;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                            arrived   <= 1'b1;
                            door_cnt  <= '0;
                        end
                    end else begin
                        move_cnt <= move_cnt + 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    // A fresh press at this floor keeps the door open longer.
                    if (call_req[current_floor]) begin
                        door_cnt <= '0;
                    end else if (door_done) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        door_cnt  <= '0;
                    end else begin
                        door_cnt <= door_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed testbench for elevator_call_scheduler; inputs driven and outputs
// sampled on the falling clock edge.
module tb_elevator_call_scheduler;

    localparam int NF = 16;
    localparam int FW = 4;
    localparam int MC = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_req = '0;
    logic [NF-1:0] pending;
    logic [FW-1:0] current_floor;
    logic [FW-1:0] target_floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic          arrived;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elevator_call_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .MOVE_CYCLES (MC),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .pending       (pending),
        .current_floor (current_floor),
        .target_floor  (target_floor),
        .dir_up        (dir_up),
        .moving        (moving),
        .door_open     (door_open),
        .arrived       (arrived)
    );

    // The car must never be travelling past either end of the shaft.
    always @(negedge clk) begin
        if (reset === 1'b1 && moving === 1'b1) begin
            checks++;
            if ((dir_up && current_floor == 4'd15) || (!dir_up && current_floor == 4'd0)) begin
                errors++;
                $display("FAIL saturation: floor %0d dir_up %0b while moving", current_floor, dir_up);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        call_req = '0;
        reset    = 1'b0;
        cyc(2);
        reset    = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL rst_pending: got %0h expected 0", pending); end
        checks++; if (current_floor !== 4'd0) begin errors++; $display("FAIL rst_floor: got %0d expected 0", current_floor); end
        checks++; if (target_floor !== 4'd0) begin errors++; $display("FAIL rst_target: got %0d expected 0", target_floor); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL rst_dir: got %0b expected 1", dir_up); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL rst_moving: got %0b expected 0", moving); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL rst_door: got %0b expected 0", door_open); end
        checks++; if (arrived !== 1'b0) begin errors++; $display("FAIL rst_arrived: got %0b expected 0", arrived); end
        @(negedge clk);
        reset = 1'b1;
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single_call;
        do_reset();
        call_req = 16'h0020;
        cyc(1);
        call_req = '0;
        checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL t1_pending: got %0h expected 20", pending); end
        checks++; if (target_floor !== 4'd5) begin errors++; $display("FAIL t1_target: got %0d expected 5", target_floor); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL t1_idle: got moving %0b expected 0", moving); end
        cyc(1);
        checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin errors++; $display("FAIL t1_start: got moving %0b dir %0b expected 1 1", moving, dir_up); end
        for (int f = 1; f <= 5; f++) begin
            cyc(MC);
            checks++; if (current_floor !== FW'(f)) begin errors++; $display("FAIL t1_step: got floor %0d expected %0d", current_floor, f); end
            if (f < 5) begin
                checks++; if (arrived !== 1'b0) begin errors++; $display("FAIL t1_early_arrive: got %0b expected 0 at floor %0d", arrived, f); end
            end
        end
        checks++; if (arrived !== 1'b1 || door_open !== 1'b1) begin errors++; $display("FAIL t1_arrive: got arrived %0b door %0b expected 1 1", arrived, door_open); end
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL t1_cleared: got %0h expected 0", pending); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL t1_stopped: got moving %0b expected 0", moving); end
        cyc(1);
        checks++; if (arrived !== 1'b0 || door_open !== 1'b1) begin errors++; $display("FAIL t1_pulse: got arrived %0b door %0b expected 0 1", arrived, door_open); end
        cyc(6);
        checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL t1_door_hold: got %0b expected 1", door_open); end
        cyc(1);
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL t1_door_close: got %0b expected 0", door_open); end
        $display("test_single_call done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_mid_travel;
        do_reset();
        call_req = 16'h0200;
        cyc(1);
        call_req = '0;
        cyc(9);
        checks++; if (current_floor !== 4'd2) begin errors++; $display("FAIL t2_at2: got %0d expected 2", current_floor); end
        call_req = 16'h0040;
        cyc(1);
        call_req = '0;
        checks++; if (target_floor !== 4'd6) begin errors++; $display("FAIL t2_target6: got %0d expected 6", target_floor); end
        checks++; if (pending !== 16'h0240) begin errors++; $display("FAIL t2_pending: got %0h expected 240", pending); end
        cyc(15);
        checks++; if (current_floor !== 4'd6 || arrived !== 1'b1) begin errors++; $display("FAIL t2_stop6: got floor %0d arrived %0b expected 6 1", current_floor, arrived); end
        checks++; if (pending !== 16'h0200 || target_floor !== 4'd9) begin errors++; $display("FAIL t2_rest: got pending %0h target %0d expected 200 9", pending, target_floor); end
        cyc(DC);
        checks++; if (door_open !== 1'b0 || moving !== 1'b0) begin errors++; $display("FAIL t2_idle: got door %0b moving %0b expected 0 0", door_open, moving); end
        cyc(1);
        checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin errors++; $display("FAIL t2_resume: got moving %0b dir %0b expected 1 1", moving, dir_up); end
        cyc(12);
        checks++; if (current_floor !== 4'd9 || arrived !== 1'b1 || pending !== 16'h0) begin errors++; $display("FAIL t2_stop9: got floor %0d arrived %0b pending %0h expected 9 1 0", current_floor, arrived, pending); end
        $display("test_mid_travel done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_look_reversal;
        do_reset();
        call_req = 16'h0100;
        cyc(1);
        call_req = '0;
        cyc(33);
        checks++; if (current_floor !== 4'd8 || arrived !== 1'b1) begin errors++; $display("FAIL t3_at8: got floor %0d arrived %0b expected 8 1", current_floor, arrived); end
        cyc(DC);
        checks++; if (door_open !== 1'b0 || dir_up !== 1'b1) begin errors++; $display("FAIL t3_idle8: got door %0b dir %0b expected 0 1", door_open, dir_up); end
        call_req = 16'h1008;
        cyc(1);
        call_req = '0;
        checks++; if (target_floor !== 4'd12 || pending !== 16'h1008) begin errors++; $display("FAIL t3_target12: got target %0d pending %0h expected 12 1008", target_floor, pending); end
        cyc(1);
        checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin errors++; $display("FAIL t3_up: got moving %0b dir %0b expected 1 1", moving, dir_up); end
        cyc(16);
        checks++; if (current_floor !== 4'd12 || arrived !== 1'b1 || pending !== 16'h0008) begin errors++; $display("FAIL t3_stop12: got floor %0d arrived %0b pending %0h expected 12 1 8", current_floor, arrived, pending); end
        cyc(DC);
        checks++; if (door_open !== 1'b0 || dir_up !== 1'b1 || target_floor !== 4'd12) begin errors++; $display("FAIL t3_hold_dir: got door %0b dir %0b target %0d expected 0 1 12", door_open, dir_up, target_floor); end
        cyc(1);
        checks++; if (moving !== 1'b1 || dir_up !== 1'b0 || target_floor !== 4'd3) begin errors++; $display("FAIL t3_reverse: got moving %0b dir %0b target %0d expected 1 0 3", moving, dir_up, target_floor); end
        cyc(36);
        checks++; if (current_floor !== 4'd3 || arrived !== 1'b1 || pending !== 16'h0) begin errors++; $display("FAIL t3_stop3: got floor %0d arrived %0b pending %0h expected 3 1 0", current_floor, arrived, pending); end
        $display("test_look_reversal done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_door_retrigger;
        int arr_cnt;
        int door_cnt;
        bit pend_seen;
        arr_cnt   = 0;
        door_cnt  = 0;
        pend_seen = 1'b0;
        do_reset();
        call_req = 16'h0010;
        cyc(1);
        call_req = '0;
        cyc(17);
        checks++; if (current_floor !== 4'd4 || door_open !== 1'b1) begin errors++; $display("FAIL t4_open: got floor %0d door %0b expected 4 1", current_floor, door_open); end
        for (int k = 0; k < 30; k++) begin
            if (arrived) arr_cnt++;
            if (door_open) door_cnt++;
            if (pending[4]) pend_seen = 1'b1;
            call_req = (k == 2 || k == 7 || k == 12) ? 16'h0010 : 16'h0000;
            cyc(1);
        end
        call_req = '0;
        checks++; if (arr_cnt != 1) begin errors++; $display("FAIL t4_arrived_count: got %0d expected 1", arr_cnt); end
        checks++; if (door_cnt != 21) begin errors++; $display("FAIL t4_door_cycles: got %0d expected 21", door_cnt); end
        checks++; if (pend_seen != 1'b0) begin errors++; $display("FAIL t4_pending4: got set %0b expected 0", pend_seen); end
        $display("test_door_retrigger done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_top_floor;
        do_reset();
        call_req = 16'h8000;
        cyc(1);
        call_req = '0;
        cyc(61);
        checks++; if (current_floor !== 4'd15 || arrived !== 1'b1) begin errors++; $display("FAIL t5_at15: got floor %0d arrived %0b expected 15 1", current_floor, arrived); end
        cyc(DC);
        call_req = 16'h8000;
        cyc(1);
        call_req = '0;
        checks++; if (pending !== 16'h8000 || door_open !== 1'b0 || target_floor !== 4'd15) begin errors++; $display("FAIL t5_latched: got pending %0h door %0b target %0d expected 8000 0 15", pending, door_open, target_floor); end
        cyc(1);
        checks++; if (door_open !== 1'b1 || arrived !== 1'b1 || moving !== 1'b0 || current_floor !== 4'd15) begin errors++; $display("FAIL t5_reopen: got door %0b arrived %0b moving %0b floor %0d expected 1 1 0 15", door_open, arrived, moving, current_floor); end
        cyc(DC);
        call_req = 16'h4000;
        cyc(1);
        call_req = '0;
        cyc(MC);
        checks++; if (arrived !== 1'b0 || current_floor !== 4'd15 || moving !== 1'b1 || dir_up !== 1'b0) begin errors++; $display("FAIL t5_adj_early: got arrived %0b floor %0d moving %0b dir %0b expected 0 15 1 0", arrived, current_floor, moving, dir_up); end
        cyc(1);
        checks++; if (arrived !== 1'b1 || current_floor !== 4'd14) begin errors++; $display("FAIL t5_adj_arrive: got arrived %0b floor %0d expected 1 14", arrived, current_floor); end
        $display("test_top_floor done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_async_reset;
        do_reset();
        call_req = 16'h1400;
        cyc(1);
        call_req = '0;
        cyc(29);
        checks++; if (current_floor !== 4'd7 || moving !== 1'b1 || pending !== 16'h1400) begin errors++; $display("FAIL t6_pre: got floor %0d moving %0b pending %0h expected 7 1 1400", current_floor, moving, pending); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pending !== 16'h0 || current_floor !== 4'd0 || target_floor !== 4'd0) begin errors++; $display("FAIL t6_regs: got pending %0h floor %0d target %0d expected 0 0 0", pending, current_floor, target_floor); end
        checks++; if (dir_up !== 1'b1 || moving !== 1'b0 || door_open !== 1'b0 || arrived !== 1'b0) begin errors++; $display("FAIL t6_flags: got dir %0b moving %0b door %0b arrived %0b expected 1 0 0 0", dir_up, moving, door_open, arrived); end
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        checks++; if (moving !== 1'b0 || current_floor !== 4'd0) begin errors++; $display("FAIL t6_after: got moving %0b floor %0d expected 0 0", moving, current_floor); end
        $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_mid_travel();
        test_look_reversal();
        test_door_retrigger();
        test_top_floor();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
